// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg : shared types and sizing for the 16x8 register file.
// Revision     : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

package reg_file_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } wr_ctrl_state_t;

    localparam int RF_PW          = 4;
    localparam int RF_DW          = 8;
    localparam int RF_STATUS_ADDR = 3;

endpackage

`default_nettype wire

// File: rtl/reg_file_wr_ctrl.sv
// -----------------------------------------------------------------------------
// reg_file_wr_ctrl : register-file write-port controller. Clears the file after
//                    reset, then arbitrates core writeback vs. a starvation-
//                    protected loader onto the single write port.
// Revision         : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module reg_file_wr_ctrl
    import reg_file_pkg::*;
#(
    parameter int PW          = RF_PW,
    parameter int DW          = RF_DW,
    parameter int MAX_WAIT    = 4,
    parameter int STATUS_ADDR = RF_STATUS_ADDR
) (
    input  logic          clk,
    input  logic          start_n,
    input  logic          core_wr_en,
    input  logic [PW-1:0] core_wr_addr,
    input  logic [DW-1:0] core_wr_dat,
    input  logic          core_flag,
    output logic          core_stall,
    input  logic          ld_valid,
    input  logic [PW-1:0] ld_addr,
    input  logic [DW-1:0] ld_dat,
    output logic          ld_ready,
    input  logic [DW-1:0] status_in,
    output logic          rf_wr_en,
    output logic [PW-1:0] rf_wr_addr,
    output logic [DW-1:0] rf_dat_in,
    output logic          rf_flag,
    output logic          init_done
);

    localparam logic [3:0]    c_max_wait    = 4'(MAX_WAIT);
    localparam logic [PW-1:0] c_last_addr   = '1;
    localparam logic [PW-1:0] c_status_addr = PW'(STATUS_ADDR);

    wr_ctrl_state_t r_state, w_state_nxt;
    logic [PW-1:0]  r_clr_cnt, w_clr_cnt_nxt;
    logic [3:0]     r_wait_cnt, w_wait_cnt_nxt;
    logic           w_ld_grant;
    logic           w_unused;

    // Only bit 0 of the status register carries the flag.
    assign w_unused = ^status_in[DW-1:1];

    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            r_state    <= CLEAR;
            r_clr_cnt  <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_cnt_nxt  = r_clr_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_ld_grant     = 1'b0;
        core_stall     = 1'b0;
        ld_ready       = 1'b0;
        rf_wr_en       = 1'b0;
        rf_wr_addr     = '0;
        rf_dat_in      = '0;
        rf_flag        = 1'b0;
        init_done      = 1'b0;

        case (r_state)
            CLEAR: begin
                rf_wr_en      = 1'b1;
                rf_wr_addr    = r_clr_cnt;
                core_stall    = core_wr_en;
                w_clr_cnt_nxt = r_clr_cnt + PW'(1);
                if (r_clr_cnt == c_last_addr) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                init_done = 1'b1;
                if (ld_valid && (r_wait_cnt == c_max_wait)) begin
                    w_ld_grant = 1'b1;
                    core_stall = core_wr_en;
                end else if (core_wr_en) begin
                    rf_wr_en   = 1'b1;
                    rf_wr_addr = core_wr_addr;
                    rf_dat_in  = core_wr_dat;
                    rf_flag    = core_flag;
                end else if (ld_valid) begin
                    w_ld_grant = 1'b1;
                end
            end
            default: w_state_nxt = CLEAR;
        endcase

        // Loader writes preserve the current flag unless they target the status register.
        if (w_ld_grant) begin
            ld_ready   = 1'b1;
            rf_wr_en   = 1'b1;
            rf_wr_addr = ld_addr;
            rf_dat_in  = ld_dat;
            rf_flag    = (ld_addr == c_status_addr) ? ld_dat[0] : status_in[0];
        end

        if (w_ld_grant || !ld_valid) begin
            w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt != c_max_wait) begin
            w_wait_cnt_nxt = r_wait_cnt + 4'd1;
        end

        if (!start_n) begin
            core_stall = 1'b0;
            ld_ready   = 1'b0;
            rf_wr_en   = 1'b0;
            rf_wr_addr = '0;
            rf_dat_in  = '0;
            rf_flag    = 1'b0;
            init_done  = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_file_wr_ctrl : self-checking bench for reg_file_wr_ctrl.
// Revision            : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_reg_file_wr_ctrl;

    localparam int DEPTH       = 16;
    localparam int MAX_WAIT    = 4;
    localparam int STATUS_ADDR = 3;

    logic       clk = 1'b0;
    logic       start_n;
    logic       core_wr_en;
    logic [3:0] core_wr_addr;
    logic [7:0] core_wr_dat;
    logic       core_flag;
    logic       core_stall;
    logic       ld_valid;
    logic [3:0] ld_addr;
    logic [7:0] ld_dat;
    logic       ld_ready;
    logic [7:0] status_in;
    logic       rf_wr_en;
    logic [3:0] rf_wr_addr;
    logic [7:0] rf_dat_in;
    logic       rf_flag;
    logic       init_done;

    int errs   = 0;
    int checks = 0;

    // Reference model state: cycles since reset release (saturating) and blocked-loader count.
    int m_sweep = 0;
    int m_wait  = 0;

    always #5 clk = ~clk;

    reg_file_wr_ctrl #(
        .PW(4), .DW(8), .MAX_WAIT(MAX_WAIT), .STATUS_ADDR(STATUS_ADDR)
    ) dut (
        .clk(clk), .start_n(start_n),
        .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr),
        .core_wr_dat(core_wr_dat), .core_flag(core_flag), .core_stall(core_stall),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_dat(ld_dat), .ld_ready(ld_ready),
        .status_in(status_in),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_dat_in(rf_dat_in),
        .rf_flag(rf_flag), .init_done(init_done)
    );

    // Packing: {wr_en, addr[3:0], dat[7:0], flag, stall, ready, done}
    function automatic logic [16:0] act_out();
        return {rf_wr_en, rf_wr_addr, rf_dat_in, rf_flag, core_stall, ld_ready, init_done};
    endfunction

    function automatic logic [16:0] exp_out();
        logic       en = 0, fl = 0, st = 0, rd = 0, dn = 0;
        logic [3:0] a = 0;
        logic [7:0] d = 0;
        bit         ldg = 0;
        if (start_n) begin
            if (m_sweep < DEPTH) begin
                en = 1; a = m_sweep[3:0]; st = core_wr_en;
            end else begin
                dn = 1;
                if (ld_valid && m_wait == MAX_WAIT) begin
                    ldg = 1; st = core_wr_en;
                end else if (core_wr_en) begin
                    en = 1; a = core_wr_addr; d = core_wr_dat; fl = core_flag;
                end else if (ld_valid) begin
                    ldg = 1;
                end
                if (ldg) begin
                    en = 1; rd = 1; a = ld_addr; d = ld_dat;
                    fl = (int'(ld_addr) == STATUS_ADDR) ? ld_dat[0] : status_in[0];
                end
            end
        end
        return {en, a, d, fl, st, rd, dn};
    endfunction

    task automatic tick();
        logic [16:0] e;
        @(posedge clk);
        e = exp_out();
        if (!start_n) begin
            m_sweep = 0;
            m_wait  = 0;
        end else begin
            if (m_sweep < DEPTH) m_sweep++;
            if (e[1] || !ld_valid)    m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
        end
        #1;
    endtask

    task automatic drive(input bit ce, input logic [3:0] ca, input logic [7:0] cd, input bit cf,
                         input bit lv, input logic [3:0] la, input logic [7:0] ldd,
                         input logic [7:0] st);
        core_wr_en = ce; core_wr_addr = ca; core_wr_dat = cd; core_flag = cf;
        ld_valid = lv; ld_addr = la; ld_dat = ldd; status_in = st;
    endtask

    task automatic rand_drive();
        drive(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic test_reset();
        start_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_drive();
            @(negedge clk);
            checks++;
            if (act_out() !== 17'h0) begin
                errs++;
                $display("FAIL reset_outputs cyc%0d: got %h required 0", i, act_out());
            end
            tick();
        end
    endtask

    task automatic test_sweep();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        start_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            checks++;
            if (act_out() !== exp_out() || rf_wr_addr !== 4'(i) || !rf_wr_en || init_done) begin
                errs++;
                $display("FAIL sweep addr%0d: got %h required %h", i, act_out(), exp_out());
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (act_out() !== exp_out() || !init_done || rf_wr_en) begin
                errs++;
                $display("FAIL sweep_done cyc%0d: got %h required %h", i, act_out(), exp_out());
            end
            tick();
        end
    endtask

    task automatic test_core_during_sweep();
        start_n = 1'b0;
        tick();
        start_n = 1'b1;
        drive(1, 4'd5, 8'h3C, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            checks++;
            if (act_out() !== exp_out() || !core_stall) begin
                errs++;
                $display("FAIL core_stall_sweep cyc%0d: got %h required %h", i, act_out(), exp_out());
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (act_out() !== exp_out() || rf_wr_addr !== 4'd5 || rf_dat_in !== 8'h3C
            || rf_flag !== 1'b1 || core_stall) begin
            errs++;
            $display("FAIL core_write_run: got %h required %h", act_out(), exp_out());
        end
        tick();
    endtask

    task automatic test_loader_only();
        drive(0, 0, 0, 0, 1, 4'd7, 8'hA5, 8'h01);
        @(negedge clk);
        checks++;
        if (act_out() !== exp_out() || !ld_ready || rf_wr_addr !== 4'd7
            || rf_dat_in !== 8'hA5 || rf_flag !== 1'b1) begin
            errs++;
            $display("FAIL loader_only: got %h required %h", act_out(), exp_out());
        end
        tick();
    endtask

    task automatic test_starvation();
        drive(1, 4'd2, 8'h11, 0, 1, 4'd9, 8'h22, 8'h00);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (act_out() !== exp_out() || ld_ready !== (i % 5 == 4) || core_stall !== (i % 5 == 4)) begin
                errs++;
                $display("FAIL starvation cyc%0d: got %h required %h", i, act_out(), exp_out());
            end
            tick();
        end
    endtask

    task automatic test_status_flag();
        drive(0, 0, 0, 0, 1, 4'd3, 8'hFE, 8'h01);
        @(negedge clk);
        checks++;
        if (act_out() !== exp_out() || rf_flag !== 1'b0 || !ld_ready) begin
            errs++;
            $display("FAIL status_flag: got %h required %h", act_out(), exp_out());
        end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        start_n = 1'b0;
        tick();
        start_n = 1'b1;
        repeat (9) tick();
        @(negedge clk);
        checks++;
        if (act_out() !== exp_out() || rf_wr_addr !== 4'd9) begin
            errs++;
            $display("FAIL mid_sweep_pos: got %h required %h", act_out(), exp_out());
        end
        start_n = 1'b0;
        #1;
        checks++;
        if (act_out() !== 17'h0) begin
            errs++;
            $display("FAIL mid_sweep_reset: got %h required 0", act_out());
        end
        tick();
        start_n = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk);
            checks++;
            if (act_out() !== exp_out() || init_done !== (i == DEPTH)) begin
                errs++;
                $display("FAIL resweep cyc%0d: got %h required %h", i, act_out(), exp_out());
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_drive();
            start_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (act_out() !== exp_out()) begin
                errs++;
                $display("FAIL random cyc%0d: got %h required %h", i, act_out(), exp_out());
            end
            tick();
        end
    endtask

    initial begin
        start_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 start_n = 1'b0;
        test_reset();
        test_sweep();
        test_core_during_sweep();
        test_loader_only();
        test_starvation();
        test_status_flag();
        test_reset_mid_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_file_wr_ctrl.md
Name: reg_file_wr_ctrl

Overview:
Write-port controller for the 16x8 register file; it owns the write inputs (wr_en, wr_addr, dat_in, flag).
- After reset it sequences a clear sweep that zeroes every register.
- It then arbitrates the single write port between core writeback (priority) and a loader (valid/ready) used for program/data preload.
- A starvation counter guarantees the loader progress.
- It sits between the core writeback stage and the register file.

Parameters:
PW, 4, address width; depth = 2**PW.
DW, 8, data width.
MAX_WAIT, 4, consecutive loader-blocked cycles before the loader is forced a grant (range 1..15).
STATUS_ADDR, 3, index of the status/flag register.

Ports:
clk  in  1  clock; all state updates on posedge.
start_n  in  1  asynchronous active-low reset.
core_wr_en  in  1  core writeback request.
core_wr_addr  in  PW  core destination register.
core_wr_dat  in  DW  core write data.
core_flag  in  1  flag value the core supplies with each write.
core_stall  out  1  core write not taken this cycle; core holds request unchanged.
ld_valid  in  1  loader write request.
ld_addr  in  PW  loader destination register.
ld_dat  in  DW  loader write data.
ld_ready  out  1  loader write accepted this cycle (transfer = ld_valid && ld_ready).
status_in  in  DW  current status register contents, read back from the register file.
rf_wr_en  out  1  register-file write enable.
rf_wr_addr  out  PW  register-file write address.
rf_dat_in  out  DW  register-file write data.
rf_flag  out  1  register-file flag input; it is written to STATUS_ADDR on every write.
init_done  out  1  clear sweep finished.

Behaviour:
- Registered state: fsm {CLEAR, RUN}, clr_cnt[PW-1:0], wait_cnt[3:0].
- Outputs are combinational from registered state and inputs.
- Reset (start_n=0, async):
  - fsm=CLEAR, clr_cnt=0, wait_cnt=0.
  - While reset is asserted, all outputs are forced to 0: rf_wr_en=0, core_stall=0, ld_ready=0, init_done=0.
- CLEAR state:
  - Drives rf_wr_en=1, rf_wr_addr=clr_cnt, rf_dat_in=0, rf_flag=0.
  - clr_cnt increments each cycle.
  - After the clr_cnt=2**PW-1 write, fsm goes to RUN. The sweep takes exactly 2**PW cycles after reset release.
  - ld_ready=0 throughout; core_stall=core_wr_en.
- RUN state: init_done=1. Grant rules, evaluated each cycle:
  - Forced-loader cycle: ld_valid && wait_cnt==MAX_WAIT. The loader is granted, ld_ready=1, core_stall=core_wr_en.
  - Else if core_wr_en: the core is granted.
    - rf_wr_addr=core_wr_addr, rf_dat_in=core_wr_dat, rf_flag=core_flag.
    - core_stall=0, ld_ready=0.
  - Else if ld_valid: the loader is granted, ld_ready=1.
  - Else: rf_wr_en=0.
- Loader grant data:
  - rf_wr_addr=ld_addr, rf_dat_in=ld_dat.
  - rf_flag = ld_dat[0] if ld_addr==STATUS_ADDR, else status_in[0]. A loader write never corrupts the flag.
- wait_cnt updates:
  - Cleared on any loader grant or when ld_valid=0.
  - Incremented when ld_valid && !ld_ready.
  - Saturates at MAX_WAIT.
- rf_wr_en = 1 exactly when some requester is granted in RUN, or always in CLEAR.
- At most one write per cycle; a granted write lands in the register file at the same posedge (zero added latency).
- Reset mid-sweep or mid-run: the sweep restarts from address 0; a pending loader or core request is dropped and must be re-presented.
- ld_valid may deassert without a transfer; wait_cnt then clears.

Decomposition:
- Package reg_file_pkg:
  - typedef enum logic {CLEAR, RUN} wr_ctrl_state_t.
  - Constants RF_PW=4, RF_DW=8, RF_STATUS_ADDR=3.
- No sub-module is needed. Grant logic and FSM stay in one always_comb plus one always_ff.

Test Plan:
1. Release reset, no requests -> 16 writes, addr 0..15, data 0, flag 0; init_done rises in cycle 16; rf_wr_en=0 afterwards.
2. During sweep, core_wr_en=1 addr 5 data 0x3C -> core_stall=1 until RUN, then write addr 5 = 0x3C with core_flag, core_stall=0.
3. RUN, ld_valid only, addr 7 data 0xA5, status_in=0x01 -> ld_ready=1 same cycle, rf_wr_addr=7, rf_dat_in=0xA5, rf_flag=1.
4. RUN, core_wr_en and ld_valid held continuously, MAX_WAIT=4 -> core granted 4 cycles, loader forced in the 5th (core_stall=1), then pattern repeats.
5. Loader write addr 3 data 0xFE, status_in=0x01 -> rf_flag=0.
6. Assert start_n low at sweep addr 9, release -> sweep restarts at addr 0, full 16 cycles, init_done low until completion.
